mult_seq_ctrl: RTL and testbench

//   Sequencer for the calculator's iterative shift-add multiplier.
//   - Accepts an operand pair from decode and runs the radix-2 datapath for WIDTH cycles.
//   - Holds PC/fetch stalled while the multiplier is busy.
//   - Returns a 2*WIDTH-bit product with a one-cycle done pulse.
//   - Sits between decode/regfile and the writeback mux; single clock domain with the core.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/mult_shift_dp.sv | 62 ++++++
 rtl/mult_seq_ctrl.sv | 114 +++++++++++
 tb/tb_mult_seq_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// ============================================================================
// calc_pkg: shared state encodings and default widths for the calculator core
// Revision: 1.0
// ============================================================================
`default_nettype none

package calc_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mult_state_t;

endpackage

`default_nettype wire

// File: rtl/mult_shift_dp.sv
// ============================================================================
// mult_shift_dp: radix-2 shift-add multiplier datapath (magnitude load, step, negate)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_shift_dp
    import calc_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               fix,
    input  logic               is_signed,
    input  logic               neg,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] full;

    // Negating -2**(W-1) in W bits yields 2**(W-1), which is correct when treated as unsigned.
    assign mag_a = (is_signed && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
    assign mag_b = (is_signed && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;

    assign sum  = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign full = {acc, mplier};

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            product <= '0;
        end else begin
            if (load) begin
                mcand  <= mag_a;
                mplier <= mag_b;
                acc    <= '0;
            end else if (step) begin
                acc    <= sum[WIDTH:1];
                mplier <= {sum[0], mplier[WIDTH-1:1]};
            end
            if (fix) begin
                product <= neg ? (~full + 1'b1) : full;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
// ============================================================================
// mult_seq_ctrl: sequencer for the iterative multiplier; FSM, counter, stall/busy/done
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_seq_ctrl
    import calc_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               abort,
    output logic               stall,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mult_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             neg;
    logic             run_fix;
    logic             load;
    logic             step;
    logic             fix;

    assign load  = (state == ST_IDLE) && start && !abort;
    assign step  = (state == ST_RUN)  && !abort;
    assign fix   = (state == ST_FIX)  && !abort;
    // The request-cycle term keeps PC from advancing before the FSM has registered the start.
    assign stall = load || run_fix;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            neg     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            run_fix <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        neg     <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        cnt     <= '0;
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                        run_fix <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        run_fix <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    run_fix <= 1'b0;
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    run_fix <= 1'b0;
                end
            endcase
        end
    end

    mult_shift_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .fix       (fix),
        .is_signed (is_signed),
        .neg       (neg),
        .op_a      (op_a),
        .op_b      (op_b),
        .product   (product)
    );

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
// ============================================================================
// tb_mult_seq_ctrl: directed bench with a cycle-level reference model for mult_seq_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mult_seq_ctrl;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          is_signed;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          abort;
    logic          stall;
    logic          busy;
    logic          done;
    logic [2*W-1:0] product;

    int tests = 0;
    int fails = 0;

    mult_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .abort     (abort),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return 64'(ua * ub);
    endfunction

    task automatic check1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%b required=%b @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1..W = iterations, W+1 = sign fix, W+2 = done.
    int          phase    = 0;
    logic [63:0] m_prod   = '0;
    logic [63:0] m_pend   = '0;
    bit          model_on = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            phase    = 0;
            m_prod   = '0;
            model_on = 1'b1;
        end else if (phase == 0) begin
            if (start && !abort) begin
                phase  = 1;
                m_pend = ref_mul(is_signed, op_a, op_b);
            end
        end else if (phase == W + 2) begin
            phase = 0;
        end else if (abort) begin
            phase = 0;
        end else begin
            phase++;
            if (phase == W + 2) m_prod = m_pend;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check1("model busy", busy, phase != 0);
            check1("model done", done, phase == W + 2);
            check1("model stall", stall,
                   (phase == 0 && start && !abort) || (phase >= 1 && phase <= W + 1));
            check64("model product", product, m_prod);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation; optionally re-fires start (9*9) at iteration inj to prove it is ignored.
    task automatic run_op(input string nm, input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] exp, input int inj);
        int n;
        int st;
        is_signed = s;
        op_a      = a;
        op_b      = b;
        start     = 1'b1;
        #1;
        check1({nm, " request stall"}, stall, 1'b1);
        cycle();
        start = 1'b0;
        n  = 1;
        st = 0;
        while (!done && n < 100) begin
            if (stall) st++;
            if (inj != 0 && n == inj) begin
                start = 1'b1; is_signed = 1'b0; op_a = 32'd9; op_b = 32'd9;
            end else begin
                start = 1'b0;
            end
            cycle();
            n++;
        end
        start = 1'b0;
        check_int({nm, " latency"}, n, 34);
        check_int({nm, " stall cycles"}, st, 33);
        check64({nm, " product"}, product, exp);
        check1({nm, " stall in done"}, stall, 1'b0);
        cycle();
        check1({nm, " done single"}, done, 1'b0);
        check64({nm, " product held"}, product, exp);
    endtask

    initial begin
        int seen;
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0; abort = 1'b0;
        cycle();
        cycle();
        check1("reset busy", busy, 1'b0);
        check1("reset done", done, 1'b0);
        check1("reset stall", stall, 1'b0);
        check64("reset product", product, 64'd0);
        reset = 1'b0;
        cycle();

        run_op("u3x5", 1'b0, 32'd3, 32'd5, 64'd15, 0);
        run_op("s-3x7", 1'b1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 0);
        run_op("umax2", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
        run_op("smin2", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
        run_op("6x7 busy start", 1'b0, 32'd6, 32'd7, 64'd42, 12);
        run_op("9x9", 1'b0, 32'd9, 32'd9, 64'd81, 0);

        // start together with abort in IDLE is dropped
        start = 1'b1; abort = 1'b1; op_a = 32'd4; op_b = 32'd4;
        #1;
        check1("idle abort stall", stall, 1'b0);
        cycle();
        start = 1'b0; abort = 1'b0;
        check1("idle abort busy", busy, 1'b0);

        // abort mid-RUN
        start = 1'b1; is_signed = 1'b0; op_a = 32'd11; op_b = 32'd13;
        cycle();
        start = 1'b0;
        repeat (9) cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check1("abort busy", busy, 1'b0);
        check1("abort stall", stall, 1'b0);
        check1("abort done", done, 1'b0);
        check64("abort product", product, 64'd81);
        seen = 0;
        repeat (40) begin
            cycle();
            if (done) seen++;
        end
        check_int("abort no done", seen, 0);

        // reset mid-RUN
        start = 1'b1; op_a = 32'd5; op_b = 32'd5;
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check1("midreset busy", busy, 1'b0);
        check1("midreset stall", stall, 1'b0);
        check1("midreset done", done, 1'b0);
        check64("midreset product", product, 64'd0);
        cycle();
        run_op("2x2 after reset", 1'b0, 32'd2, 32'd2, 64'd4, 0);

        repeat (2) cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
